ball_ctrl: RTL and testbench

BALL_CTRL -- requirements
Module: ball_ctrl

---
 rtl/ball_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ball_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Single-ball game controller: IDLE/RUN/DEAD flow, per-frame gravity/jump motion,
// horizontal steering with wall clamps, and an unsafe-zone death timer.
module ball_ctrl #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_RADIUS   = 10,
    parameter int STEP_X        = 2,
    parameter int GRAVITY       = 1,
    parameter int JUMP_VEL      = 8,
    parameter int MAX_VY        = 8,
    parameter int UNSAFE_LIMIT  = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_frame_tick,
    input  logic                              i_btn_start,
    input  logic                              i_btn_left,
    input  logic                              i_btn_right,
    input  logic                              i_btn_jump,
    input  logic                              i_is_safe,
    output logic [$clog2(SCREEN_WIDTH)-1:0]   o_ball_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0]  o_ball_y,
    output logic [1:0]                        o_state,
    output logic                              o_game_over,
    output logic [15:0]                       o_score
);

    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam int CW = $clog2(UNSAFE_LIMIT + 1);

    // All motion arithmetic is signed 12-bit so y+vy and x-STEP_X never wrap.
    localparam logic signed [11:0] X_MIN_S  = 12'(BALL_RADIUS);
    localparam logic signed [11:0] X_MAX_S  = 12'(SCREEN_WIDTH - 1 - BALL_RADIUS);
    localparam logic signed [11:0] Y_MIN_S  = 12'(BALL_RADIUS);
    localparam logic signed [11:0] FLOOR_S  = 12'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
    localparam logic signed [11:0] GRAV_S   = 12'(GRAVITY);
    localparam logic signed [11:0] JUMP_S   = 12'(JUMP_VEL);
    localparam logic signed [11:0] MAX_VY_S = 12'(MAX_VY);
    localparam logic signed [11:0] STEP_S   = 12'(STEP_X);

    localparam logic [XW-1:0] X0_U     = XW'(SCREEN_WIDTH / 2);
    localparam logic [XW-1:0] X_MIN_U  = XW'(BALL_RADIUS);
    localparam logic [XW-1:0] X_MAX_U  = XW'(SCREEN_WIDTH - 1 - BALL_RADIUS);
    localparam logic [YW-1:0] Y_MIN_U  = YW'(BALL_RADIUS);
    localparam logic [YW-1:0] FLOOR_U  = YW'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(UNSAFE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t             state;
    logic signed [7:0]  vy;
    logic [CW-1:0]      unsafe_cnt;
    logic               jump_pending;
    logic               jump_prev;

    logic               jump_rise;
    logic               jump_take;
    logic signed [11:0] vy_wide;
    logic signed [11:0] vy_grav;
    logic signed [11:0] vy_new;
    logic signed [11:0] y_cur;
    logic signed [11:0] y_next;
    logic signed [11:0] x_cur;
    logic signed [11:0] x_step;
    logic signed [11:0] x_next;
    logic [YW-1:0]      y_res;
    logic signed [7:0]  vy_res;
    logic [XW-1:0]      x_res;
    logic               death;
    logic               state_bad;
    logic               go_idle;

    assign o_state = state;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        jump_rise = i_btn_jump & ~jump_prev;
        jump_take = jump_pending | jump_rise;

        vy_wide = {{4{vy[7]}}, vy};
        vy_grav = vy_wide + GRAV_S;
        vy_new  = (vy_grav > MAX_VY_S) ? MAX_VY_S : vy_grav;
        if (jump_take) vy_new = -JUMP_S;

        y_cur  = 12'(o_ball_y);
        y_next = y_cur + vy_new;
        y_res  = YW'(y_next);
        vy_res = vy_new[7:0];
        if (y_next >= FLOOR_S) begin
            y_res  = FLOOR_U;
            vy_res = '0;
        end else if (y_next < Y_MIN_S) begin
            y_res  = Y_MIN_U;
            vy_res = '0;
        end

        x_step = '0;
        case ({i_btn_right, i_btn_left})
            2'b10:   x_step = STEP_S;
            2'b01:   x_step = -STEP_S;
            default: x_step = '0;
        endcase
        x_cur  = 12'(o_ball_x);
        x_next = x_cur + x_step;
        x_res  = XW'(x_next);
        if (x_next < X_MIN_S)      x_res = X_MIN_U;
        else if (x_next > X_MAX_S) x_res = X_MAX_U;

        // Death fires on the tick whose increment would reach the limit.
        death     = ~i_is_safe & (unsafe_cnt >= LIMIT_M1);
        state_bad = !(state inside {IDLE, RUN, DEAD});
        go_idle   = (state == IDLE) | ((state == DEAD) & i_btn_start) | state_bad;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_ball_x     <= X0_U;
            o_ball_y     <= FLOOR_U;
            vy           <= '0;
            o_score      <= '0;
            o_game_over  <= 1'b0;
            jump_pending <= 1'b0;
            jump_prev    <= 1'b0;
            unsafe_cnt   <= '0;
        end else begin
            jump_prev <= i_btn_jump;

            if (go_idle) begin
                o_ball_x     <= X0_U;
                o_ball_y     <= FLOOR_U;
                vy           <= '0;
                o_score      <= '0;
                jump_pending <= 1'b0;
                unsafe_cnt   <= '0;
                o_game_over  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_btn_start) state <= RUN;
                end
                RUN: begin
                    if (i_frame_tick) begin
                        if (death) begin
                            state       <= DEAD;
                            o_game_over <= 1'b1;
                        end else begin
                            o_ball_x     <= x_res;
                            o_ball_y     <= y_res;
                            vy           <= vy_res;
                            jump_pending <= 1'b0;
                            unsafe_cnt   <= i_is_safe ? '0 : unsafe_cnt + CW'(1);
                            if (o_score != 16'hFFFF) o_score <= o_score + 16'd1;
                        end
                    end else if (jump_rise) begin
                        jump_pending <= 1'b1;
                    end
                end
                DEAD: begin
                    if (i_btn_start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: default-size instance for motion/death/reset,
// plus a short-screen instance to reach the ceiling clamp.
module tb_ball_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0, jump = 1'b0, safe = 1'b1;
    logic [8:0] x;
    logic [9:0] y;
    logic [1:0] st;
    logic       go;
    logic [15:0] score;

    logic       s_tick = 1'b0, s_start = 1'b0, s_jump = 1'b0;
    logic       s_left = 1'b0, s_right = 1'b0, s_safe = 1'b1;
    logic [8:0] s_x;
    logic [5:0] s_y;
    logic [1:0] s_st;
    logic       s_go;
    logic [15:0] s_score;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ball_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_btn_start(start),
        .i_btn_left(left), .i_btn_right(right), .i_btn_jump(jump), .i_is_safe(safe),
        .o_ball_x(x), .o_ball_y(y), .o_state(st), .o_game_over(go), .o_score(score)
    );

    // FLOOR = 39-1-10 = 28, Y_MIN = 10: a two-step jump lands exactly on Y_MIN+3.
    ball_ctrl #(.SCREEN_HEIGHT(39)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(s_tick), .i_btn_start(s_start),
        .i_btn_left(s_left), .i_btn_right(s_right), .i_btn_jump(s_jump), .i_is_safe(s_safe),
        .o_ball_x(s_x), .o_ball_y(s_y), .o_state(s_st), .o_game_over(s_go), .o_score(s_score)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic s_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) s_tick = 1'b1;
            @(negedge clk) s_tick = 1'b0;
        end
    endtask

    task automatic press_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic jump_edge();
        @(negedge clk) jump = 1'b1;
        @(negedge clk) jump = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_x", x, 200);
        check("rst_y", y, 589);
        check("rst_state", st, 0);
        check("rst_score", score, 0);
        check("rst_game_over", go, 0);
        rst_n = 1'b1;
        @(negedge clk);
        ticks(1);
        check("idle_tick_ignored", st, 0);

        // Start and tick in the same cycle: RUN, but no motion yet
        @(negedge clk) begin start = 1'b1; tick = 1'b1; end
        @(negedge clk) begin start = 1'b0; tick = 1'b0; end
        check("start_tick_state", st, 1);
        check("start_tick_score", score, 0);
        check("start_tick_y", y, 589);
        repeat (3) @(negedge clk);
        check("no_motion_without_tick", y, 589);

        // Single jump edge, then ticks
        jump_edge();
        ticks(1); check("jump_y1", y, 581);
        ticks(1); check("jump_y2", y, 574);
        ticks(1); check("jump_y3", y, 568);
        ticks(1); check("jump_y4", y, 563);
        check("jump_score", score, 4);
        ticks(20); check("landed_y", y, 589);
        ticks(1); check("floor_rest_y", y, 589);
        check("score_25", score, 25);

        // Held jump: exactly one jump across 10 ticks
        @(negedge clk) jump = 1'b1;
        ticks(10);
        check("held_jump_y", y, 554);
        jump = 1'b0;
        ticks(20);
        check("held_jump_land", y, 589);
        check("score_55", score, 55);

        // Rising edge on the tick cycle is consumed on that tick
        @(negedge clk) begin jump = 1'b1; tick = 1'b1; end
        @(negedge clk) begin jump = 1'b0; tick = 1'b0; end
        check("tick_edge_y", y, 581);
        ticks(1);
        check("tick_edge_no_rejump", y, 574);
        ticks(20);
        check("score_77", score, 77);

        // Start ignored in RUN
        press_start();
        check("start_in_run_state", st, 1);
        check("start_in_run_score", score, 77);

        // Right held: +2 per tick, clamp at 389
        right = 1'b1;
        ticks(1);  check("right_x1", x, 202);
        ticks(9);  check("right_x10", x, 220);
        ticks(90); check("right_clamp", x, 389);
        check("score_177", score, 177);
        left = 1'b1;
        ticks(5);  check("both_buttons", x, 389);
        right = 1'b0;
        ticks(1);  check("left_step", x, 387);
        left = 1'b0;

        // Asynchronous reset in RUN
        @(negedge clk) rst_n = 1'b0;
        #2;
        check("mid_rst_state", st, 0);
        check("mid_rst_x", x, 200);
        check("mid_rst_y", y, 589);
        check("mid_rst_score", score, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", st, 0);

        // Unsafe pattern 0,0,1,0,0,0 -> DEAD on 6th tick
        press_start();
        check("restart_run", st, 1);
        right = 1'b1;
        safe = 1'b0; ticks(2);
        safe = 1'b1; ticks(1);
        safe = 1'b0; ticks(2);
        check("pre_death_state", st, 1);
        check("pre_death_x", x, 210);
        check("pre_death_go", go, 0);
        ticks(1);
        check("death_state", st, 2);
        check("death_go", go, 1);
        check("death_x_frozen", x, 210);
        check("death_y_frozen", y, 589);
        check("death_score", score, 5);
        jump_edge();
        ticks(3);
        check("dead_hold_x", x, 210);
        check("dead_hold_y", y, 589);
        check("dead_hold_score", score, 5);
        right = 1'b0;
        safe = 1'b1;
        press_start();
        check("dead_to_idle", st, 0);
        check("dead_to_idle_go", go, 0);
        check("dead_to_idle_x", x, 200);
        check("dead_to_idle_score", score, 0);
        press_start();
        check("idle_to_run_again", st, 1);

        // Ceiling clamp on the short screen
        check("s_floor", s_y, 28);
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        check("s_run", s_st, 1);
        @(negedge clk) s_jump = 1'b1;
        @(negedge clk) s_jump = 1'b0;
        s_ticks(1); check("s_y1", s_y, 20);
        s_ticks(1); check("s_y_min_plus3", s_y, 13);
        @(negedge clk) begin s_jump = 1'b1; s_tick = 1'b1; end
        @(negedge clk) begin s_jump = 1'b0; s_tick = 1'b0; end
        check("s_ceiling_clamp", s_y, 10);
        s_ticks(1); check("s_vy_zeroed", s_y, 11);
        check("s_score", s_score, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
